// File: rtl/fifo_rd_ctrl.sv
// Read side of the dual-clock FIFO: write-pointer sync, Gray read pointer, empty flag, registered-read memory port.
// wr pointer to m_valid is 4 edges; a 2-entry output buffer absorbs m_ready stalls at 1 word/cycle. FIFO_RD_LEVEL_EN adds rd_level.
module fifo_rd_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic [ADDRSIZE:0]   wr_ptr_gray,
  output logic [ADDRSIZE:0]   rd_ptr_gray,
  output logic                mem_rd_en,
  output logic                mem_rd_empty,
  output logic [ADDRSIZE-1:0] mem_rd_addr,
  input  logic [DATASIZE-1:0] mem_rd_data,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ADDRSIZE:0]   rd_level
);

  logic [ADDRSIZE:0]   wq1, wq2;
  logic [ADDRSIZE:0]   rd_bin, rd_bin_next, rd_gray_next;
  logic                empty, issue, pop, inflight;
  logic [1:0]          held;
  logic [2:0]          occ_next;
  logic                head, tail;
  logic [DATASIZE-1:0] obuf [2];

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wr_ptr_gray;
      wq2 <= wq1;
    end
  end

  // Words buffered or on their way after this cycle; issuing is safe only if that leaves a free slot.
  assign pop          = m_valid && m_ready;
  assign occ_next     = {1'b0, held} + {2'b00, inflight} - {2'b00, pop};
  assign issue        = !empty && (occ_next < 3'd2);
  assign rd_bin_next  = rd_bin + {{ADDRSIZE{1'b0}}, issue};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

  assign mem_rd_en    = issue;
  assign mem_rd_empty = empty;
  assign mem_rd_addr  = rd_bin[ADDRSIZE-1:0];

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      inflight    <= 1'b0;
    end else begin
      rd_bin      <= rd_bin_next;
      rd_ptr_gray <= rd_gray_next;
      empty       <= (rd_gray_next == wq2);
      inflight    <= issue;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      held    <= 2'd0;
      head    <= 1'b0;
      tail    <= 1'b0;
      obuf[0] <= '0;
      obuf[1] <= '0;
    end else begin
      if (inflight) begin
        obuf[tail] <= mem_rd_data;
        tail       <= ~tail;
      end
      if (pop) head <= ~head;
      case ({inflight, pop})
        2'b10:   held <= held + 2'd1;
        2'b01:   held <= held - 2'd1;
        default: held <= held;
      endcase
    end
  end

  assign m_valid = (held != 2'd0);
  assign m_data  = obuf[head];

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDRSIZE:0] wq2_bin;

  always_comb begin
    wq2_bin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) wq2_bin[i] = ^(wq2 >> i);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) rd_level <= '0;
    else           rd_level <= wq2_bin - rd_bin;
  end
`else
  assign rd_level = '0;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the dual-clock FIFO, living entirely in the read clock domain. It synchronizes the write pointer, maintains the Gray-coded read pointer and empty flag, and drives the read port of `fifomem` (registered read, one-cycle latency). It repackages the memory output as a valid/ready stream through a 2-entry output buffer, so downstream back-pressure never drops data and the steady-state rate is one word per cycle.

## Interface
Parameters:
- DATASIZE, 8, data word width
- ADDRSIZE, 4, memory address bits; DEPTH = 1<<ADDRSIZE; pointers are ADDRSIZE+1 bits

Ports:
- rd_clk  in  1  read-domain clock; every register samples on its rising edge
- rd_rst_n  in  1  reset, asynchronous, active-low
- wr_ptr_gray  in  ADDRSIZE+1  Gray write pointer from the write domain, unsynchronized
- rd_ptr_gray  out  ADDRSIZE+1  registered Gray read pointer, sent to the write domain
- mem_rd_en  out  1  read strobe to memory (combinational)
- mem_rd_empty  out  1  registered empty flag to memory
- mem_rd_addr  out  ADDRSIZE  read address, equal to rd_bin[ADDRSIZE-1:0]
- mem_rd_data  in  DATASIZE  memory read data, valid the cycle after an accepted strobe
- m_data  out  DATASIZE  stream data (head of output buffer)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- rd_level  out  ADDRSIZE+1  words in the FIFO not yet issued (see Configuration)

## Operation
- Synchronizer: wr_ptr_gray → wq1 → wq2. Both flops are plain; no logic between them.
- Pointers: rd_bin and rd_ptr_gray (= rd_bin ^ (rd_bin>>1)) are registered. Both advance by 1 on each issue and wrap modulo 2^(ADDRSIZE+1).
- Empty: registered. `empty <= (rd_gray_next == wq2)`, where rd_gray_next is the pointer after this cycle's issue.
- Issue: issue = !empty && (held + inflight − pop < 2), with pop = m_valid && m_ready. Outputs mem_rd_en = issue and mem_rd_empty = empty.
- inflight: a 1-bit register set to issue.
- Capture: when inflight is 1, mem_rd_data is written into the output buffer tail.
- Output buffer:
  - 2-entry FIFO with a `held` count of 0..2.
  - m_valid = (held != 0); m_data is the head entry.
  - The buffer never accepts a capture when it is full; the issue rule guarantees this.
  - Data is delivered in pointer order with no duplication.
- Simultaneous pop and capture in one cycle: held is unchanged, the head advances and the tail is written.
- Wrap: the address wraps DEPTH−1 → 0, and the pointer MSB toggles on each wrap.
- Full FIFO: a Gray difference of DEPTH is handled identically to any nonzero difference.
- Reset (async assert, at any time including mid-stream): the following clear to 0 and any in-flight word is discarded:
  - rd_bin, rd_ptr_gray, wq1, wq2
  - held, inflight, buffer head/tail
  - rd_level

  empty resets to 1. Resulting output values: m_valid=0, m_data=0, mem_rd_en=0, mem_rd_empty=1, mem_rd_addr=0. The write domain is reset concurrently; this is a system requirement.

## Timing
- wr_ptr_gray stable before edge N: wq2 updates at N+1, empty falls at N+2, mem_rd_en is high in cycle N+2..N+3, memory reads at N+3, capture at N+4, and m_valid=1 after edge N+4.
- Pop to pointer: a pop at edge K enables the next issue in the same cycle. rd_ptr_gray reflects each issue one edge later.
- Throughput: 1 word/cycle with m_ready held high and FIFO non-empty.
- Under stall: m_data and m_valid hold stable while m_valid && !m_ready.
- rd_level is registered, 1 cycle after wq2 or rd_bin change.

## Configuration
- FIFO_RD_LEVEL_EN defined:
  - wq2 is converted Gray→binary.
  - rd_level <= wq2_bin − rd_bin, modulo 2^(ADDRSIZE+1), range 0..DEPTH.
- FIFO_RD_LEVEL_EN undefined: rd_level is constant 0 and the Gray→binary conversion logic is absent.

## Test plan
- Reset: assert rd_rst_n=0 mid-cycle → outputs go immediately to m_valid=0, mem_rd_empty=1, rd_ptr_gray=0, rd_level=0.
- Single word: mem[0]=0xA5, wr_ptr_gray 0→5'b00001 before edge N → m_valid=1 after edge N+4 with m_data=0xA5. Pop → rd_ptr_gray=5'b00001 and empty=1 again.
- Back-pressure: 16 words preloaded, wr_ptr_gray=5'b11000, m_ready=0 → exactly 2 mem_rd_en pulses and m_data stable at word0. Raise m_ready → words 0..15 delivered in order, one per cycle.
- Wrap: stream 40 words through DEPTH=16 → mem_rd_addr wraps 15→0, rd_ptr_gray follows the Gray sequence with the MSB toggling at words 16 and 32, and there is no loss or duplication.
- Level (macro on): synced write pointer 10 and rd_bin=3 → rd_level=7. With the macro off → rd_level=0.
- Reset mid-stream: assert reset with held=2 and inflight=1 → after release, m_valid=0 and rd_ptr_gray=0; a subsequent single-word test passes.
